// File: rtl/prg_loader.sv
// PRG / cartridge download parser: header or raw base address, byte writes,
// then BASIC end-pointer injection and optional reset request.
module prg_loader #(
  parameter int              AW             = 16,
  parameter logic [15:0]     RAW_BASE       = 16'hA000,
  parameter logic [15:0]     AUTORESET_ADDR = 16'hA000,
  parameter int              NPTR           = 8,
  parameter logic [NPTR*AW-1:0] PTR_LIST    = {16'hAF, 16'hAE, 16'h32,
                                               16'h31, 16'h30, 16'h2F,
                                               16'h2E, 16'h2D},
  parameter int              INJ_GAP        = 2,
  parameter int              RST_HOLD       = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [7:0]    dl_data,
  input  logic          raw_mode,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          busy,
  output logic [AW-1:0] end_addr,
  output logic          force_reset
);

  localparam int IW = $clog2(NPTR + 1);
  localparam int GW = $clog2(INJ_GAP + 1);
  localparam int RW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_INJECT,
    S_RST
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic [7:0]    hdr_lo, hdr_lo_n;
  logic [IW-1:0] idx, idx_n;
  logic [GW-1:0] cnt, cnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          autoreset, autoreset_n;
  logic          wr_n;
  logic [AW-1:0] addr_n;
  logic [7:0]    data_n;
  logic          act_q;
  logic          rise, fall;

  // follows dl_active through reset so a held level is not seen as a rise
  always_ff @(posedge clk_sys)
    act_q <= dl_active;

  assign rise     = dl_active & ~act_q;
  assign fall     = ~dl_active & act_q;
  assign end_addr = ptr;

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    hdr_lo_n    = hdr_lo;
    idx_n       = idx;
    cnt_n       = cnt;
    rcnt_n      = rcnt;
    autoreset_n = autoreset;
    wr_n        = 1'b0;
    addr_n      = mem_addr;
    data_n      = mem_data;
    if (rise) begin
      autoreset_n = 1'b0;
      idx_n       = '0;
      cnt_n       = '0;
      if (raw_mode) begin
        ptr_n   = AW'(RAW_BASE);
        state_n = S_DATA;
      end else begin
        state_n = S_HDR_LO;
      end
    end else begin
      unique case (state)
        S_IDLE: ;
        S_HDR_LO: begin
          if (fall) begin
            state_n = S_IDLE;
          end else if (dl_wr) begin
            hdr_lo_n = dl_data;
            state_n  = S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (fall) begin
            state_n = S_IDLE;
          end else if (dl_wr) begin
            ptr_n   = AW'({dl_data, hdr_lo});
            state_n = S_DATA;
          end
        end
        S_DATA: begin
          if (dl_wr) begin
            wr_n   = 1'b1;
            addr_n = ptr;
            data_n = dl_data;
            ptr_n  = ptr + AW'(1);
            if (ptr == AW'(AUTORESET_ADDR))
              autoreset_n = 1'b1;
          end
          if (fall) begin
            state_n = S_INJECT;
            idx_n   = '0;
            cnt_n   = GW'(INJ_GAP - 1);
            // no byte in flight: first pointer write goes out right away
            if (!dl_wr) begin
              wr_n   = 1'b1;
              addr_n = PTR_LIST[AW-1:0];
              data_n = ptr[7:0];
              idx_n  = IW'(1);
            end
          end
        end
        S_INJECT: begin
          if (cnt != '0) begin
            cnt_n = cnt - GW'(1);
          end else if (idx == IW'(NPTR)) begin
            if (autoreset) begin
              state_n = S_RST;
              rcnt_n  = RW'(RST_HOLD - 1);
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            wr_n   = 1'b1;
            addr_n = PTR_LIST[int'(idx)*AW +: AW];
            data_n = idx[0] ? ptr[15:8] : ptr[7:0];
            idx_n  = idx + IW'(1);
            // trailing gap after the last write is one cycle longer
            cnt_n  = (idx == IW'(NPTR - 1)) ? GW'(INJ_GAP)
                                            : GW'(INJ_GAP - 1);
          end
        end
        S_RST: begin
          if (rcnt == '0) begin
            autoreset_n = 1'b0;
            state_n     = S_IDLE;
          end else begin
            rcnt_n = rcnt - RW'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      hdr_lo      <= '0;
      idx         <= '0;
      cnt         <= '0;
      rcnt        <= '0;
      autoreset   <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      busy        <= 1'b0;
      force_reset <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hdr_lo      <= hdr_lo_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      rcnt        <= rcnt_n;
      autoreset   <= autoreset_n;
      mem_wr      <= wr_n;
      mem_addr    <= addr_n;
      mem_data    <= data_n;
      busy        <= (state_n != S_IDLE);
      force_reset <= (state_n == S_RST);
    end
  end

endmodule
